coord_scanner: RTL
==================

Name: coord_scanner

Overview:
- Sequential coordinate walker, the driving end of the per-sample coordinate step path.
- Given a block origin (x0, y0), emits every (X, Y) sample coordinate of a BLK_W x BLK_H block, one per accepted handshake.
- Order is raster, forward (increment) or reverse (decrement).
- Feeds downstream sample-fetch and motion-compensation logic with signed 8-bit coordinates.

Parameters:
- CW, 8, coordinate width in bits (signed two's complement).
- BLK_W, 4, block width in samples (2..16).
- BLK_H, 4, block height in samples (2..16).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- start  input  1  begin a scan; sampled only in IDLE.
- dir  input  1  0 = forward (increment), 1 = reverse (decrement); latched with start.
- x0  input  CW  signed block origin X; latched with start.
- y0  input  CW  signed block origin Y; latched with start.
- out_ready  input  1  consumer accepts the current coordinate.
- out_valid  output  1  x_out/y_out hold a valid coordinate.
- x_out  output  CW  signed X coordinate.
- y_out  output  CW  signed Y coordinate.
- out_last  output  1  current coordinate is the final one of the block.
- busy  output  1  scan in progress (state != IDLE).
- done  output  1  one-cycle pulse after the final coordinate is accepted.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; out_valid, x_out, y_out, out_last, busy, done all 0; column/row counters 0.
- States: IDLE, SCAN, DONE.
- IDLE -> SCAN on start=1.
  - Latch dir, x0, y0.
  - Next cycle: out_valid=1 with the first coordinate. Latency start to first valid is 1 cycle.
  - Forward first coordinate = (x0, y0).
  - Reverse first coordinate = (x0+BLK_W-1, y0+BLK_H-1).
- SCAN:
  - Coordinate advances only on out_valid && out_ready.
  - While out_ready=0, x_out, y_out, out_valid and out_last hold stable.
  - X steps by +1 (forward) or -1 (reverse) per accept.
  - At the end of a row, X reloads to the row start and Y steps by +1 or -1.
- out_last=1 exactly while the coordinate with column=BLK_W-1 and row=BLK_H-1 (scan-order indices) is presented.
- Accept with out_last=1 -> DONE.
  - out_valid drops to 0 the next cycle.
  - done=1 for exactly one cycle.
- DONE -> IDLE unconditionally after one cycle. start is ignored in SCAN and DONE (no queuing).
- Arithmetic:
  - CW-bit two's-complement add of the step (+1 or -1), wrap-around, no saturation, no overflow flag.
  - Example: 127 + 1 = -128.
  - Counters are $clog2(BLK_W) and $clog2(BLK_H) bits, unsigned.
- busy = 1 in SCAN and DONE.
- Throughput: one coordinate per cycle with out_ready held at 1. Total block time = BLK_W*BLK_H cycles + 1 (DONE).
- Reset mid-scan aborts immediately. No done pulse; outputs return to reset values.

Optional Feature:
- Macro: COORD_SNAKE_SCAN_EN.
- Defined: serpentine order. Odd rows (scan-order index) traverse X in the opposite direction to even rows. No X reload at row end; only Y steps. The final coordinate therefore depends on BLK_H parity.
  - Forward, BLK_H even: last = (x0, y0+BLK_H-1).
  - Reverse: mirrored.
- Undefined: plain raster as above. No snake logic is synthesised.

Decomposition:
- Package coord_pkg:
  - CW default constant.
  - State encoding IDLE=2'd0, SCAN=2'd1, DONE=2'd2.
  - Direction constants DIR_FWD=1'b0, DIR_REV=1'b1.
- Sub-module coord_step: combinational signed CW-bit add of a ±1 step selected by a direction bit, wrap-around. Instantiated twice, once for X and once for Y.
- Counters and the FSM stay in coord_scanner.

Test Plan:
- Forward, BLK_W=BLK_H=4, start with x0=10, y0=-3, dir=0, out_ready=1 -> 16 coordinates:
  - (10,-3),(11,-3),(12,-3),(13,-3),(10,-2) … (13,0).
  - out_last only on (13,0); done pulses 1 cycle later; busy low after 18 cycles.
- Reverse, x0=0, y0=0, dir=1 -> first coordinate (3,3), then (2,3),(1,3),(0,3),(3,2) …; last (0,0).
- Wrap, forward, x0=126, y0=127 -> row 0 X = 126,127,-128,-127; row 1 Y = -128.
- Backpressure: out_ready toggled 1,0,0,1 -> coordinate held stable across both stall cycles; no coordinate skipped or duplicated; count = 16.
- start asserted mid-scan -> ignored, sequence unchanged. rst_n pulled low at coordinate 5 -> outputs 0 immediately, no done; a new start after release scans from its new origin.
- COORD_SNAKE_SCAN_EN defined, forward, x0=0, y0=0 -> row 1 emits (3,1),(2,1),(1,1),(0,1); last = (0,3).

Source files
------------

// File: rtl/coord_pkg.sv
// rtl/coord_pkg.sv - shared constants and state encoding for the coordinate scanner
package coord_pkg;

    localparam int CW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/coord_step.sv
// rtl/coord_step.sv - wrap-around signed +1/-1 step of one coordinate
module coord_step import coord_pkg::*; #(
    parameter int CW = CW_DEF
) (
    input  logic signed [CW-1:0] a_i,
    input  logic                 dir_i,
    output logic signed [CW-1:0] y_o
);

    assign y_o = (dir_i == DIR_REV) ? a_i - CW'(1) : a_i + CW'(1);

endmodule

// File: rtl/coord_scanner.sv
// rtl/coord_scanner.sv - raster walker over a BLK_W x BLK_H sample block
// Optional serpentine order when COORD_SNAKE_SCAN_EN is defined.
module coord_scanner import coord_pkg::*; #(
    parameter int CW    = CW_DEF,
    parameter int BLK_W = 4,
    parameter int BLK_H = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 dir,
    input  logic signed [CW-1:0] x0,
    input  logic signed [CW-1:0] y0,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic signed [CW-1:0] x_out,
    output logic signed [CW-1:0] y_out,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);

    localparam int XW = $clog2(BLK_W);
    localparam int YW = $clog2(BLK_H);
    localparam logic [XW-1:0] COL_END = XW'(BLK_W - 1);
    localparam logic [YW-1:0] ROW_END = YW'(BLK_H - 1);

    state_e                 state_q, state_d;
    logic                   dir_q, dir_d;
    logic signed [CW-1:0]   x_q, x_d, y_q, y_d;
    logic signed [CW-1:0]   x_nxt, y_nxt;
    logic [XW-1:0]          col_q, col_d;
    logic [YW-1:0]          row_q, row_d;
    logic                   x_dir;
    logic                   at_row_end, at_last;

`ifdef COORD_SNAKE_SCAN_EN
    // Odd rows run X against the scan direction, so X never reloads.
    assign x_dir = dir_q ^ row_q[0];
`else
    logic signed [CW-1:0]   xs_q, xs_d;
    assign x_dir = dir_q;
`endif

    coord_step #(.CW(CW)) u_step_x (.a_i(x_q), .dir_i(x_dir), .y_o(x_nxt));
    coord_step #(.CW(CW)) u_step_y (.a_i(y_q), .dir_i(dir_q), .y_o(y_nxt));

    assign at_row_end = (col_q == COL_END);
    assign at_last    = at_row_end && (row_q == ROW_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dir_q   <= DIR_FWD;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
            row_q   <= '0;
`ifndef COORD_SNAKE_SCAN_EN
            xs_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
            row_q   <= row_d;
`ifndef COORD_SNAKE_SCAN_EN
            xs_q    <= xs_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        x_d     = x_q;
        y_d     = y_q;
        col_d   = col_q;
        row_d   = row_q;
`ifndef COORD_SNAKE_SCAN_EN
        xs_d    = xs_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    dir_d   = dir;
                    col_d   = '0;
                    row_d   = '0;
                    // Reverse scans begin at the far corner of the block.
                    if (dir == DIR_REV) begin
                        x_d = x0 + CW'(BLK_W - 1);
                        y_d = y0 + CW'(BLK_H - 1);
                    end else begin
                        x_d = x0;
                        y_d = y0;
                    end
`ifndef COORD_SNAKE_SCAN_EN
                    xs_d = x_d;
`endif
                end
            end
            SCAN: begin
                if (out_ready) begin
                    if (at_row_end) begin
                        col_d = '0;
                        y_d   = y_nxt;
`ifndef COORD_SNAKE_SCAN_EN
                        x_d   = xs_q;
`endif
                        if (at_last) begin
                            state_d = DONE;
                            row_d   = '0;
                        end else begin
                            row_d = row_q + YW'(1);
                        end
                    end else begin
                        col_d = col_q + XW'(1);
                        x_d   = x_nxt;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign out_valid = (state_q == SCAN);
    assign out_last  = (state_q == SCAN) && at_last;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign x_out     = x_q;
    assign y_out     = y_q;

endmodule
